// File: rtl/mem_access_pipe_pkg.sv
// Shared types for the memory-stage pipeline: micro-op layout, cache command and FSM states.
`default_nettype none

package mem_access_pipe_pkg;

  typedef logic [7:0] opcode_t;
  localparam opcode_t MLOAD  = 8'h20;
  localparam opcode_t MLOADS = 8'h21;
  localparam opcode_t MSTORE = 8'h22;

  typedef enum logic [3:0] {
    SZ_1 = 4'd1,
    SZ_2 = 4'd2,
    SZ_4 = 4'd4,
    SZ_8 = 4'd8
  } mem_size_t;

  typedef struct packed {
    logic [63:0] val;
  } reg_val_t;

  typedef struct packed {
    opcode_t     opcode;
    mem_size_t   size;
    logic [5:0]  dst_id;
    logic [31:0] disp;
    reg_val_t    src0_val;
    reg_val_t    src1_val;
    reg_val_t    dst_val;
  } micro_op_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cache_cmd_t;

  typedef logic [2:0] mem_state_t;
  localparam mem_state_t S_IDLE = 3'd0;
  localparam mem_state_t S_RD0  = 3'd1;
  localparam mem_state_t S_RD1  = 3'd2;
  localparam mem_state_t S_WR0  = 3'd3;
  localparam mem_state_t S_WR1  = 3'd4;
  localparam mem_state_t S_DONE = 3'd5;

  // Anything other than 1/2/4/8 bytes behaves as a full doubleword.
  function automatic logic [3:0] norm_size(input logic [3:0] s);
    logic [3:0] r;
    case (s)
      4'd1, 4'd2, 4'd4, 4'd8: r = s;
      default:                r = 4'd8;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_pipe_byte_lane.sv
// Little-endian byte lane: load extract/extend and store byte-merge over {word1, word0}.
`default_nettype none

module mem_byte_lane (
  input  logic [63:0] word0,
  input  logic [63:0] word1,
  input  logic [2:0]  off,
  input  logic [3:0]  size,
  input  logic        sign_ext,
  input  logic [63:0] st_data,
  output logic [63:0] load_val,
  output logic [63:0] merged0,
  output logic [63:0] merged1
);

  logic [127:0] pair;
  logic [127:0] dshift;
  logic [127:0] merged;
  logic [63:0]  raw;
  logic [7:0]   bmask;
  logic [15:0]  mask16;

  always_comb begin
    pair = {word1, word0};
    raw  = 64'(pair >> {off, 3'b000});
    case (size)
      4'd1:    load_val = sign_ext ? {{56{raw[7]}}, raw[7:0]}   : {56'd0, raw[7:0]};
      4'd2:    load_val = sign_ext ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      4'd4:    load_val = sign_ext ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
      default: load_val = raw;
    endcase

    case (size)
      4'd1:    bmask = 8'h01;
      4'd2:    bmask = 8'h03;
      4'd4:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
    // Store bytes may spill past byte 7 into word1 on a split access.
    mask16 = {8'd0, bmask} << off;
    dshift = {64'd0, st_data} << {off, 3'b000};
    merged = pair;
    for (int i = 0; i < 16; i++) begin
      if (mask16[i]) merged[i*8 +: 8] = dshift[i*8 +: 8];
    end
  end

  assign merged0 = merged[63:0];
  assign merged1 = merged[127:64];

endmodule

`default_nettype wire

// File: rtl/mem_access_pipe.sv
// Memory-stage pipeline: EA generation, aligned cache accesses with split and read-modify-write.
`default_nettype none

module mem_access_pipe
  import mem_access_pipe_pkg::*;
#(
  parameter int MOP_W  = $bits(micro_op_t),
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_ready,
  input  logic [MOP_W-1:0]  in_mop,
  output logic              busy,
  output logic              out_ready,
  output logic [MOP_W-1:0]  out_mop,
  output cache_cmd_t        ca_req_cmd,
  output logic [ADDR_W-1:0] ca_req_addr,
  output logic [63:0]       ca_req_data,
  input  logic              ca_respcyc,
  input  logic [63:0]       ca_resp_data
);

  mem_state_t        state, state_nx;
  micro_op_t         mop, in_m, done_mop;
  logic [ADDR_W-1:0] ea, in_ea, ea_cur, w0_addr, w1_addr;
  logic [63:0]       word0, word1, w0_eff, w1_eff;
  logic [63:0]       load_val, merged0, merged1;
  logic [3:0]        size_n;
  logic [2:0]        off;
  logic              split, is_store, resp_rd0, resp_rd1, direct_store;

  assign in_m    = in_mop;
  assign in_ea   = ADDR_W'(in_m.src0_val.val + {{32{in_m.disp[31]}}, in_m.disp});
  assign size_n  = norm_size(mop.size);
  assign off     = ea[2:0];
  assign split   = ({1'b0, off} + size_n) > 4'd8;
  assign is_store = (mop.opcode == MSTORE);

  // A full aligned doubleword store needs no read-back of the old contents.
  assign direct_store = (in_m.opcode == MSTORE) && (norm_size(in_m.size) == 4'd8)
                        && (in_ea[2:0] == 3'd0);

  // Response data feeds the lane in the same cycle it arrives so the next request is ready.
  assign resp_rd0 = (state == S_RD0) && ca_respcyc;
  assign resp_rd1 = (state == S_RD1) && ca_respcyc;
  assign w0_eff   = resp_rd0 ? ca_resp_data : word0;
  assign w1_eff   = resp_rd1 ? ca_resp_data : word1;

  assign ea_cur  = (state == S_IDLE) ? in_ea : ea;
  assign w0_addr = {ea_cur[ADDR_W-1:3], 3'b000};
  assign w1_addr = w0_addr + ADDR_W'(8);

  mem_byte_lane u_lane (
    .word0    (w0_eff),
    .word1    (w1_eff),
    .off      (off),
    .size     (size_n),
    .sign_ext (mop.opcode == MLOADS),
    .st_data  (mop.src1_val.val),
    .load_val (load_val),
    .merged0  (merged0),
    .merged1  (merged1)
  );

  always_comb begin
    done_mop = mop;
    if (!is_store) done_mop.dst_val.val = load_val;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_ready) state_nx = direct_store ? S_WR0 : S_RD0;
      S_RD0:  if (ca_respcyc) state_nx = split ? S_RD1 : (is_store ? S_WR0 : S_DONE);
      S_RD1:  if (ca_respcyc) state_nx = is_store ? S_WR0 : S_DONE;
      S_WR0:  if (ca_respcyc) state_nx = split ? S_WR1 : S_DONE;
      S_WR1:  if (ca_respcyc) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mop         <= '0;
      ea          <= '0;
      word0       <= '0;
      word1       <= '0;
      busy        <= 1'b0;
      out_ready   <= 1'b0;
      out_mop     <= '0;
      ca_req_cmd  <= CMD_NONE;
      ca_req_addr <= '0;
      ca_req_data <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != S_IDLE);
      out_ready <= (state_nx == S_DONE);
      if (state == S_IDLE && in_ready) begin
        mop <= in_m;
        ea  <= in_ea;
      end
      if (resp_rd0) word0 <= ca_resp_data;
      if (resp_rd1) word1 <= ca_resp_data;
      if (state_nx == S_DONE) out_mop <= done_mop;

      // Request outputs follow the next state, so they hold until the response is taken.
      case (state_nx)
        S_RD0: begin
          ca_req_cmd  <= CMD_READ;
          ca_req_addr <= w0_addr;
          ca_req_data <= '0;
        end
        S_RD1: begin
          ca_req_cmd  <= CMD_READ;
          ca_req_addr <= w1_addr;
          ca_req_data <= '0;
        end
        S_WR0: begin
          ca_req_cmd  <= CMD_WRITE;
          ca_req_addr <= w0_addr;
          ca_req_data <= (state == S_IDLE) ? in_m.src1_val.val : merged0;
        end
        S_WR1: begin
          ca_req_cmd  <= CMD_WRITE;
          ca_req_addr <= w1_addr;
          ca_req_data <= merged1;
        end
        default: begin
          ca_req_cmd  <= CMD_NONE;
          ca_req_addr <= '0;
          ca_req_data <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
